bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Shares the single RAM port between the instruction and data caches of two cores; it sits between the four cache-side request channels and the RAM model. Each grant is one-word for icache and up to a two-word block burst for dcache. A dcache write-back or fill pair is never interleaved with another requester's traffic. Priority is dcache over icache, with round-robin fairness between cores.

## Interface
- CPUS, 2: number of cores (fixed at 2 for this revision).
- CLK  in  1  system clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN[c]  in  1  icache c read request.
- iaddr[c]  in  32  icache c word address.
- iwait[c]  out  1  low for exactly the cycle iload[c] is valid.
- iload[c]  out  32  read data to icache c.
- dREN[c], dWEN[c]  in  1  dcache c read/write request.
- daddr[c]  in  32  dcache c word address.
- dstore[c]  in  32  write data from dcache c.
- dwait[c]  out  1  low for the completion cycle of a dcache c word.
- dload[c]  out  32  read data to dcache c.
- ramREN, ramWEN  out  1  RAM read/write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  FREE, BUSY, ACCESS, ERROR.

## Operation
- Requester IDs: 0=dcache0, 1=dcache1, 2=icache0, 3=icache1. A 2-bit owner register and a 1-bit rr pointer (the core served last) are held.
- States: IDLE, GRANT.
- IDLE selection order:
  - Any dcache request beats any icache request.
  - Among dcaches, the core != rr wins if both are requesting; likewise among icaches.
  - With a request present: latch owner, latch blk = addr[31:3], clear words, go to GRANT.
  - With no request: stay in IDLE.
- GRANT:
  - Drive ramREN/ramWEN/ramaddr/ramstore from the owner's channel.
  - If dWEN and dREN are both high, the access is a write.
- On ramstate==ACCESS:
  - Pull the owner's wait low for that cycle.
  - Route ramload to the owner's load bus.
  - Increment words.
- Release conditions, each going to IDLE and setting rr = owner's core:
  - icache owner: after 1 word.
  - dcache owner: after 2 words.
  - dcache owner: when daddr[31:3] != blk after a completed word.
- Request withdrawn by the owner before ACCESS: return to IDLE that cycle; no ack; rr unchanged.
- ramstate BUSY, FREE or ERROR in GRANT: hold all strobes, wait stays high. An ERROR word is retried until ACCESS.
- Non-owners always see wait=1 and load=0.

## Timing
- Reset values:
  - All iwait and dwait = 1.
  - ramREN, ramWEN = 0; ramaddr, ramstore = 0; all load buses = 0.
  - State IDLE, owner 0, rr 0, words 0.
- Arbitration latency is 1 cycle: a request seen in IDLE drives RAM on the next edge. Minimum single-word turnaround is request cycle + 1 GRANT cycle with ACCESS.
- A dcache block burst holds the grant continuously. Both words reach RAM back-to-back with no gap and no foreign access between them.
- After release there is one IDLE cycle before the next grant, including re-grant to the same requester.
- Requests arriving in the ACCESS/release cycle are evaluated in the following IDLE cycle.
- Asynchronous reset mid-GRANT takes effect immediately: strobes drop and all waits go high. The partial burst is abandoned; the dcache restarts it.

## Structure
- ramstate_t and word_t come from cpu_types_pkg.
- Add to cpu_types_pkg:
  - arb_state_t (IDLE, GRANT).
  - ARB_BURST_WORDS = 2.
- The core-level round-robin pick is one sub-module, rr_pick: 2 requests + rr pointer -> winner index + valid. It is instantiated twice, for the dcache class and the icache class.

## Test plan
- Single icache0 read of 0x0000_0040, RAM returns 0xDEADBEEF with 2 BUSY cycles -> iwait[0] low for exactly one cycle with iload[0]=0xDEADBEEF; ramREN drops the next cycle.
- dcache0 write-back of 0x100/0x104 while icache1 requests 0x200 throughout -> RAM sees 0x100 then 0x104 with no gap, then 0x200 after one IDLE cycle.
- dcache0 and dcache1 both request continuously, rr=0 at reset -> grants alternate dcache1, dcache0, dcache1; neither is served twice in a row.
- dcache0 address changes from 0x100 to 0x208 after the first word -> grant released after one word; 0x208 is re-arbitrated.
- ramstate ERROR for 3 cycles, then ACCESS, on a dcache1 read -> dwait[1] stays high through ERROR and goes low once.
- nRST asserted during the second burst word -> all waits read 1 and strobes read 0 immediately; after release, the first grant goes to the highest-priority requester.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types plus the RAM-port arbiter's states and constants.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package cpu_types_pkg;

    localparam int CPUS            = 2;
    localparam int ARB_BURST_WORDS = 2;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Requester ids: 0=dcache0, 1=dcache1, 2=icache0, 3=icache1.
    // Bit 1 selects the cache class, bit 0 is the core.
    typedef logic [1:0] req_id_t;

    // Block index of a word address; a dcache burst never leaves its block.
    function automatic logic [28:0] blk_of(input word_t a);
        return a[31:3];
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Cache-side request channels and the single RAM port seen by the arbiter.
// Latency: none (wiring only).
// Backpressure: iwait/dwait held high until RAM reports ACCESS for the owner.
interface bus_arbiter_if;
    import cpu_types_pkg::*;

    // instruction caches
    logic [CPUS-1:0] iREN;
    word_t           iaddr [CPUS];
    logic [CPUS-1:0] iwait;
    word_t           iload [CPUS];

    // data caches
    logic [CPUS-1:0] dREN;
    logic [CPUS-1:0] dWEN;
    word_t           daddr  [CPUS];
    word_t           dstore [CPUS];
    logic [CPUS-1:0] dwait;
    word_t           dload  [CPUS];

    // RAM port
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    // caches and RAM model
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // arbiter
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/rr_pick.sv
// Two-way round-robin pick: chooses the core that was not served last on a tie.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick (
    input  logic [1:0] req,
    input  logic       rr,
    output logic       win,
    output logic       vld
);

    // a lone requester always wins; on a tie the core != rr wins
    always_comb begin
        vld = |req;
        win = 1'b0;
        if (req[0] && req[1]) begin
            win = ~rr;
        end else if (req[1]) begin
            win = 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one RAM port among dcache0/1 and icache0/1; dcache pairs are atomic.
// Latency: request seen in IDLE drives RAM the next cycle; one IDLE cycle after each release.
// Backpressure: owner's wait stays high until ramstate==ACCESS; non-owners always wait.
module bus_arbiter
    import cpu_types_pkg::*;
(
    input  logic         CLK,
    input  logic         nRST,
    bus_arbiter_if.slave bus
);

    localparam logic [1:0] BURST_LAST = 2'(ARB_BURST_WORDS - 1);

    arb_state_t  state,  state_n;
    req_id_t     owner,  owner_n;
    logic        rr,     rr_n;
    logic [1:0]  words,  words_n;
    logic [28:0] blk,    blk_n;

    logic [1:0]  dreq;
    logic        d_win, d_vld;
    logic        i_win, i_vld;

    logic        own_core;
    logic        own_i;
    logic        own_req;
    logic        own_wr;
    word_t       own_addr;
    word_t       own_store;
    logic        blk_moved;
    logic        live;
    logic        ack;

    // a dcache write with dREN also high is still a write
    assign dreq = bus.dREN | bus.dWEN;

    rr_pick u_pick_d (
        .req (dreq),
        .rr  (rr),
        .win (d_win),
        .vld (d_vld)
    );

    rr_pick u_pick_i (
        .req (bus.iREN),
        .rr  (rr),
        .win (i_win),
        .vld (i_vld)
    );

    // view of the owner's channel, and whether the RAM is being driven for it
    always_comb begin
        own_core  = owner[0];
        own_i     = owner[1];
        own_req   = own_i ? bus.iREN[own_core]  : dreq[own_core];
        own_wr    = ~own_i & bus.dWEN[own_core];
        own_addr  = own_i ? bus.iaddr[own_core] : bus.daddr[own_core];
        own_store = own_i ? '0                  : bus.dstore[own_core];
        // a dcache that moved to another block after a word gets no more words
        blk_moved = ~own_i && (words != 2'd0) && (blk_of(own_addr) != blk);
        live      = (state == GRANT) && own_req && !blk_moved;
        ack       = live && (bus.ramstate == ACCESS);
    end

    // arbitration and grant bookkeeping
    always_comb begin
        state_n = state;
        owner_n = owner;
        rr_n    = rr;
        words_n = words;
        blk_n   = blk;
        case (state)
            IDLE: begin
                if (d_vld || i_vld) begin
                    owner_n = d_vld ? {1'b0, d_win} : {1'b1, i_win};
                    blk_n   = d_vld ? blk_of(bus.daddr[d_win]) : blk_of(bus.iaddr[i_win]);
                    words_n = 2'd0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (!own_req) begin
                    // withdrawn: drop the grant without touching fairness
                    state_n = IDLE;
                end else if (blk_moved) begin
                    state_n = IDLE;
                    rr_n    = own_core;
                end else if (ack) begin
                    words_n = words + 2'd1;
                    if (own_i || (words == BURST_LAST)) begin
                        state_n = IDLE;
                        rr_n    = own_core;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // RAM strobes follow the owner's channel; completion is steered back to it
    always_comb begin
        bus.ramREN   = live & ~own_wr;
        bus.ramWEN   = live & own_wr;
        bus.ramaddr  = live ? own_addr : '0;
        bus.ramstore = (live && own_wr) ? own_store : '0;
        bus.iwait    = '1;
        bus.dwait    = '1;
        for (int c = 0; c < CPUS; c++) begin
            bus.iload[c] = '0;
            bus.dload[c] = '0;
        end
        if (ack) begin
            if (own_i) begin
                bus.iwait[own_core] = 1'b0;
                bus.iload[own_core] = bus.ramload;
            end else begin
                bus.dwait[own_core] = 1'b0;
                bus.dload[own_core] = bus.ramload;
            end
        end
    end

    // state registers; reset abandons any burst in flight
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            owner <= '0;
            rr    <= 1'b0;
            words <= '0;
            blk   <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            rr    <= rr_n;
            words <= words_n;
            blk   <= blk_n;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scenarios followed by random cache traffic against a transaction-level model.
// Latency: n/a (testbench).
// Backpressure: caches hold each request until their wait drops.
module tb_bus_arbiter;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST;

    always #5 CLK = ~CLK;

    bus_arbiter_if bus ();

    bus_arbiter dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    word_t ram_mem [word_t];
    word_t ref_mem [word_t];

    // power-on RAM contents
    function automatic word_t init_val(input word_t a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic word_t ram_rd(input word_t a);
        return ram_mem.exists(a) ? ram_mem[a] : init_val(a);
    endfunction

    function automatic word_t ref_rd(input word_t a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // RAM model: present state, answer reads, then sample away from the edge
    task automatic settle(input ramstate_t st);
        bus.ramstate = st;
        #1;
        bus.ramload = ram_rd(bus.ramaddr);
        @(negedge CLK);
        if (st == ACCESS && bus.ramWEN) ram_mem[bus.ramaddr] = bus.ramstore;
    endtask

    task automatic clear_inputs();
        bus.iREN = '0;
        bus.dREN = '0;
        bus.dWEN = '0;
        for (int c = 0; c < CPUS; c++) begin
            bus.iaddr[c]  = '0;
            bus.daddr[c]  = '0;
            bus.dstore[c] = '0;
        end
    endtask

    // spec rule: dcache class first, and on a tie the core not served last wins
    function automatic int exp_winner(input logic [3:0] req, input logic last);
        if (req[1:0] == 2'b11) return last ? 0 : 1;
        if (req[1:0] != 2'b00) return req[0] ? 0 : 1;
        if (req[3:2] == 2'b11) return last ? 2 : 3;
        if (req[3:2] != 2'b00) return req[2] ? 2 : 3;
        return -1;
    endfunction

    // random-phase cache state
    logic [3:0] act;
    logic [3:0] wr;
    word_t      base [4];
    int         idx  [4];
    word_t      wd   [4][2];

    function automatic word_t addr_of(input int r);
        return (r < 2) ? base[r] + 32'(4 * idx[r]) : base[r];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        word_t      starts [$];
        word_t      t3_exp [3];
        logic       prev_s;
        logic       strobe;
        int         lows;
        logic       found;
        ramstate_t  st;
        logic [3:0] prev_req;
        logic [3:0] cur_req;
        logic       last_core;
        logic       prev_done;
        int         owner;
        logic       exp_ack;
        logic       w;
        word_t      ld;
        word_t      a;

        // ---------------- reset ----------------
        nRST = 1'b0;
        clear_inputs();
        bus.ramstate = FREE;
        bus.ramload  = '0;
        ram_mem[32'h40] = 32'hDEADBEEF;
        repeat (2) @(negedge CLK);
        check("rst_iwait",    32'(bus.iwait),  32'h3);
        check("rst_dwait",    32'(bus.dwait),  32'h3);
        check("rst_ramREN",   32'(bus.ramREN), 32'h0);
        check("rst_ramWEN",   32'(bus.ramWEN), 32'h0);
        check("rst_ramaddr",  bus.ramaddr,     32'h0);
        check("rst_ramstore", bus.ramstore,    32'h0);
        check("rst_iload0",   bus.iload[0],    32'h0);
        check("rst_dload1",   bus.dload[1],    32'h0);
        tick();
        nRST = 1'b1;
        settle(FREE);
        check("post_rst_idle", 32'(bus.ramREN | bus.ramWEN), 32'h0);

        // ---------------- both dcaches, rr=0 at reset ----------------
        t3_exp = '{32'h400, 32'h300, 32'h400};
        prev_s = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            bus.dREN     = 2'b11;
            bus.daddr[0] = 32'h300;
            bus.daddr[1] = 32'h400;
            settle(ACCESS);
            strobe = bus.ramREN | bus.ramWEN;
            if (strobe && !prev_s) starts.push_back(bus.ramaddr);
            prev_s = strobe;
        end
        check("rr_grant_count", 32'(starts.size()), 32'd3);
        for (int i = 0; i < 3 && i < starts.size(); i++) check("rr_grant_order", starts[i], t3_exp[i]);
        tick();
        clear_inputs();
        settle(FREE);

        // ---------------- single icache0 read with 2 BUSY cycles ----------------
        tick();
        bus.iREN[0]  = 1'b1;
        bus.iaddr[0] = 32'h40;
        settle(FREE);
        check("ic_arb_cycle", 32'(bus.ramREN), 32'h0);
        lows = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            settle((k < 2) ? BUSY : ACCESS);
            check("ic_ramREN", 32'(bus.ramREN), 32'h1);
            check("ic_ramaddr", bus.ramaddr, 32'h40);
            if (!bus.iwait[0]) begin
                lows++;
                check("ic_iload", bus.iload[0], 32'hDEADBEEF);
            end
        end
        tick();
        settle(FREE);
        check("ic_ren_drop", 32'(bus.ramREN), 32'h0);
        check("ic_wait_back", 32'(bus.iwait[0]), 32'h1);
        check("ic_load_clear", bus.iload[0], 32'h0);
        check("ic_wait_lows", 32'(lows), 32'd1);
        tick();
        clear_inputs();
        settle(FREE);
        tick();
        settle(FREE);

        // ---------------- dcache0 write-back vs icache1 ----------------
        tick();
        bus.dWEN[0]   = 1'b1;
        bus.daddr[0]  = 32'h100;
        bus.dstore[0] = 32'h1111_0100;
        bus.iREN[1]   = 1'b1;
        bus.iaddr[1]  = 32'h200;
        settle(FREE);
        check("wb_arb_cycle", 32'(bus.ramWEN), 32'h0);
        tick();
        settle(ACCESS);
        check("wb_w0_wen", 32'(bus.ramWEN), 32'h1);
        check("wb_w0_addr", bus.ramaddr, 32'h100);
        check("wb_w0_data", bus.ramstore, 32'h1111_0100);
        check("wb_w0_dwait", 32'(bus.dwait[0]), 32'h0);
        check("wb_w0_iwait", 32'(bus.iwait[1]), 32'h1);
        tick();
        bus.daddr[0]  = 32'h104;
        bus.dstore[0] = 32'h2222_0104;
        settle(ACCESS);
        check("wb_w1_wen", 32'(bus.ramWEN), 32'h1);
        check("wb_w1_addr", bus.ramaddr, 32'h104);
        tick();
        bus.dWEN[0] = 1'b0;
        settle(ACCESS);
        check("wb_gap", 32'(bus.ramREN | bus.ramWEN), 32'h0);
        tick();
        settle(ACCESS);
        check("wb_ic_addr", bus.ramaddr, 32'h200);
        check("wb_ic_wait", 32'(bus.iwait[1]), 32'h0);
        check("wb_ic_load", bus.iload[1], init_val(32'h200));
        tick();
        clear_inputs();
        settle(FREE);

        // ---------------- dcache0 leaves its block after one word ----------------
        tick();
        bus.dREN[0]  = 1'b1;
        bus.daddr[0] = 32'h100;
        settle(FREE);
        tick();
        settle(ACCESS);
        check("blk_w0_addr", bus.ramaddr, 32'h100);
        check("blk_w0_load", bus.dload[0], 32'h1111_0100);
        tick();
        bus.daddr[0] = 32'h208;
        settle(ACCESS);
        check("blk_release_ren", 32'(bus.ramREN), 32'h0);
        check("blk_release_wait", 32'(bus.dwait[0]), 32'h1);
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            tick();
            settle(ACCESS);
            if (bus.ramREN && bus.ramaddr == 32'h208) begin
                found = 1'b1;
                check("blk_new_load", bus.dload[0], init_val(32'h208));
            end
        end
        check("blk_regrant", 32'(found), 32'h1);
        tick();
        clear_inputs();
        settle(FREE);

        // ---------------- ERROR retries on dcache1 read ----------------
        tick();
        bus.dREN[1]  = 1'b1;
        bus.daddr[1] = 32'h500;
        settle(FREE);
        for (int k = 0; k < 3; k++) begin
            tick();
            settle(ERROR);
            check("err_wait_high", 32'(bus.dwait[1]), 32'h1);
            check("err_hold_ren", 32'(bus.ramREN), 32'h1);
        end
        tick();
        settle(ACCESS);
        check("err_access_wait", 32'(bus.dwait[1]), 32'h0);
        check("err_access_load", bus.dload[1], init_val(32'h500));
        tick();
        clear_inputs();
        settle(FREE);
        check("err_wait_after", 32'(bus.dwait[1]), 32'h1);
        tick();
        settle(FREE);

        // ---------------- reset during the second burst word ----------------
        tick();
        bus.dWEN[0]   = 1'b1;
        bus.daddr[0]  = 32'h600;
        bus.dstore[0] = 32'h0000_1234;
        bus.iREN[0]   = 1'b1;
        bus.iaddr[0]  = 32'h700;
        settle(FREE);
        tick();
        settle(ACCESS);
        check("rb_w0_addr", bus.ramaddr, 32'h600);
        tick();
        bus.daddr[0]  = 32'h604;
        bus.dstore[0] = 32'h0000_5678;
        bus.dREN[1]   = 1'b1;
        bus.daddr[1]  = 32'h900;
        settle(BUSY);
        check("rb_w1_wen", 32'(bus.ramWEN), 32'h1);
        check("rb_w1_addr", bus.ramaddr, 32'h604);
        #1;
        nRST = 1'b0;
        #1;
        check("rb_iwait", 32'(bus.iwait), 32'h3);
        check("rb_dwait", 32'(bus.dwait), 32'h3);
        check("rb_strobes", 32'({bus.ramREN, bus.ramWEN}), 32'h0);
        tick();
        nRST = 1'b1;
        bus.daddr[0] = 32'h600;
        settle(FREE);
        check("rb_idle", 32'(bus.ramREN | bus.ramWEN), 32'h0);
        tick();
        settle(FREE);
        check("rb_first_ren", 32'(bus.ramREN), 32'h1);
        check("rb_first_addr", bus.ramaddr, 32'h900);
        tick();
        clear_inputs();
        settle(FREE);

        // ---------------- random traffic ----------------
        tick();
        nRST = 1'b0;
        settle(FREE);
        tick();
        nRST = 1'b1;
        settle(FREE);
        act       = '0;
        wr        = '0;
        prev_s    = 1'b0;
        prev_req  = '0;
        prev_done = 1'b0;
        last_core = 1'b0;
        owner     = 0;
        for (int r = 0; r < 4; r++) begin
            base[r] = '0;
            idx[r]  = 0;
        end
        for (int cyc = 0; cyc < 900; cyc++) begin
            if (cyc >= 400 && act == 4'b0) break;
            tick();
            for (int r = 0; r < 4; r++) begin
                if (cyc < 400 && !act[r] && $urandom_range(0, 3) == 0) begin
                    act[r]   = 1'b1;
                    idx[r]   = 0;
                    wr[r]    = (r < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                    base[r]  = 32'h0001_0000 | (32'(r) << 12) | (32'($urandom_range(0, 511)) << 3);
                    wd[r][0] = $urandom;
                    wd[r][1] = $urandom;
                end
            end
            for (int c = 0; c < 2; c++) begin
                bus.dWEN[c]   = act[c] & wr[c];
                bus.dREN[c]   = act[c] & (wr[c] ? 1'($urandom_range(0, 1)) : 1'b1);
                bus.daddr[c]  = addr_of(c);
                bus.dstore[c] = wd[c][idx[c] % 2];
                bus.iREN[c]   = act[c + 2];
                bus.iaddr[c]  = base[c + 2];
            end
            cur_req = act;
            case ($urandom_range(0, 5))
                0:       st = BUSY;
                1:       st = FREE;
                2:       st = ERROR;
                default: st = ACCESS;
            endcase
            settle(st);
            strobe = bus.ramREN | bus.ramWEN;
            if (prev_done) check("rnd_idle_after_release", 32'(strobe), 32'h0);
            if (strobe && !prev_s) begin
                owner = int'(bus.ramaddr[13:12]);
                check("rnd_winner", 32'(owner), 32'(exp_winner(prev_req, last_core)));
            end
            if (strobe) begin
                check("rnd_ramaddr", bus.ramaddr, addr_of(owner));
                check("rnd_ramWEN", 32'(bus.ramWEN), 32'(owner < 2 && wr[owner]));
                if (owner < 2 && wr[owner]) check("rnd_ramstore", bus.ramstore, wd[owner][idx[owner] % 2]);
            end
            prev_done = 1'b0;
            for (int r = 0; r < 4; r++) begin
                exp_ack = strobe && (st == ACCESS) && (r == owner);
                w  = (r < 2) ? bus.dwait[r % 2] : bus.iwait[r % 2];
                ld = (r < 2) ? bus.dload[r % 2] : bus.iload[r % 2];
                check("rnd_wait", 32'(w), 32'(!exp_ack));
                if (exp_ack) begin
                    a = addr_of(r);
                    if (r < 2 && wr[r]) ref_mem[a] = wd[r][idx[r] % 2];
                    else check("rnd_load", ld, ref_rd(a));
                    idx[r]++;
                    if (r >= 2 || idx[r] == ARB_BURST_WORDS) begin
                        act[r]    = 1'b0;
                        last_core = 1'(r % 2);
                        prev_done = 1'b1;
                    end
                end else begin
                    check("rnd_load_zero", ld, 32'h0);
                end
            end
            prev_s   = strobe;
            prev_req = cur_req;
        end
        check("rnd_drained", 32'(act), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
